// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/collect control path.
// State encoding, default core latency and the divide-by-zero quotient fill.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } div_state_e;

    // A divide-by-zero returns an all-ones quotient of whatever width is in use.
    localparam logic DBZ_FILL_BIT = 1'b1;

    // Worst-case cycles the shift-subtract core needs from start to stable result.
    function automatic int div_latency(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/collect stage for the shift-subtract divider: one division in flight.
// Latency: WAIT_CYCLES+2 cycles accept-to-result, 1 cycle for divide-by-zero.
// Backpressure: in_ready only in IDLE; result held stable until out_ready.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int WAIT_CYCLES = div_latency(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_dividend,
    input  logic [WIDTH-1:0]     in_divisor,
    output logic                 div_start,
    output logic [2*WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    input  logic [2*WIDTH-1:0]   div_quotient,
    input  logic [2*WIDTH-1:0]   div_remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_quotient,
    output logic [2*WIDTH-1:0]   out_remainder,
    output logic                 out_dbz
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    div_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   quo_q, quo_d;
    logic [2*WIDTH-1:0]   rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        div_start = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d = in_dividend;
                    dvs_d = in_divisor;
                    if (in_divisor == '0) begin
                        // Zero divisor never reaches the core; answer immediately.
                        quo_d   = {(2*WIDTH){DBZ_FILL_BIT}};
                        rem_d   = in_dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                div_start = 1'b1;
                cnt_d     = CNT_LOAD;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;
    assign out_dbz       = dbz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider core standing in for the real one.
module tb_div_issue_ctrl;

    localparam int WIDTH = 4;
    localparam int WC    = 2 * WIDTH + 2;
    localparam int NORM_LAT = WC + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [3:0] in_divisor;
    logic       div_start;
    logic [7:0] div_dividend;
    logic [3:0] div_divisor;
    logic [7:0] div_quotient;
    logic [7:0] div_remainder;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quotient;
    logic [7:0] out_remainder;
    logic       out_dbz;

    always #5 clk = ~clk;

    div_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz)
    );

    // Core stand-in: result only becomes correct WC edges after it sees the start pulse.
    logic [7:0] core_q, core_r;
    int         core_cnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            core_cnt <= 0;
        end else if (div_start) begin
            core_cnt <= WC;
            core_q   <= (div_divisor != 0) ? 8'(div_dividend / div_divisor) : 8'hFF;
            core_r   <= (div_divisor != 0) ? 8'(div_dividend % div_divisor) : div_dividend;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign div_quotient  = (core_cnt == 1) ? core_q : ~core_q;
    assign div_remainder = (core_cnt == 1) ? core_r : ~core_r;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } res_t;

    res_t resq[$];
    int   accq[$];
    int   cyc = 0;
    int   start_cnt = 0;
    int   dbl_start = 0;
    logic prev_start = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && div_start) start_cnt = start_cnt + 1;
        if (rst_n && div_start && prev_start) dbl_start = dbl_start + 1;
        prev_start = div_start;
        if (rst_n && in_valid && in_ready) accq.push_back(cyc);
        if (rst_n && out_valid && out_ready) resq.push_back('{out_quotient, out_remainder, out_dbz});
    end

    int nvec = 0;
    int nerr = 0;

    function automatic res_t ref_div(input int a, input int b);
        res_t r;
        if (b == 0) begin
            r.q = 8'hFF; r.r = 8'(a); r.dbz = 1'b1;
        end else begin
            r.q = 8'(a / b); r.r = 8'(a % b); r.dbz = 1'b0;
        end
        return r;
    endfunction

    function automatic int ref_lat(input int b);
        return (b == 0) ? 1 : NORM_LAT;
    endfunction

    // Issues one request and returns at the first negedge with out_valid high.
    task automatic do_req(input int a, input int b, output res_t got, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid    = 1'b1;
        in_dividend = 8'(a);
        in_divisor  = 4'(b);
        @(negedge clk);
        in_valid    = 1'b0;
        in_dividend = 8'($urandom);
        in_divisor  = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = '{out_quotient, out_remainder, out_dbz};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_dividend = 8'd0; in_divisor = 4'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (div_start !== 1'b0) begin nerr++; $display("FAIL reset_div_start got %b want 0", div_start); end
        nvec++; if ({out_quotient, out_remainder, out_dbz} !== 17'd0)
            begin nerr++; $display("FAIL reset_outputs got %h/%h/%b want 0", out_quotient, out_remainder, out_dbz); end
        nvec++; if ({div_dividend, div_divisor} !== 12'd0)
            begin nerr++; $display("FAIL reset_operands got %h/%h want 0", div_dividend, div_divisor); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   a_t[4] = '{100, 255, 5, 0};
        int   b_t[4] = '{7, 1, 9, 3};
        res_t got, exp;
        int   lat, s0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0  = start_cnt;
            exp = ref_div(a_t[i], b_t[i]);
            do_req(a_t[i], b_t[i], got, lat);
            @(negedge clk);
            nvec++; if (got.q !== exp.q) begin nerr++; $display("FAIL basic_q[%0d] got %0d want %0d", i, got.q, exp.q); end
            nvec++; if (got.r !== exp.r) begin nerr++; $display("FAIL basic_r[%0d] got %0d want %0d", i, got.r, exp.r); end
            nvec++; if (got.dbz !== exp.dbz) begin nerr++; $display("FAIL basic_dbz[%0d] got %b want %b", i, got.dbz, exp.dbz); end
            nvec++; if (lat != ref_lat(b_t[i])) begin nerr++; $display("FAIL basic_lat[%0d] got %0d want %0d", i, lat, ref_lat(b_t[i])); end
            nvec++; if (start_cnt - s0 != 1) begin nerr++; $display("FAIL basic_starts[%0d] got %0d want 1", i, start_cnt - s0); end
            nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL basic_idle[%0d] got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_dbz();
        res_t got;
        int   lat, s0;
        out_ready = 1'b1;
        s0 = start_cnt;
        do_req(77, 0, got, lat);
        @(negedge clk);
        repeat (WC + 4) @(negedge clk);
        nvec++; if (got.q !== 8'hFF) begin nerr++; $display("FAIL dbz_q got %h want ff", got.q); end
        nvec++; if (got.r !== 8'd77) begin nerr++; $display("FAIL dbz_r got %0d want 77", got.r); end
        nvec++; if (got.dbz !== 1'b1) begin nerr++; $display("FAIL dbz_flag got %b want 1", got.dbz); end
        nvec++; if (lat != 1) begin nerr++; $display("FAIL dbz_lat got %0d want 1", lat); end
        nvec++; if (start_cnt != s0) begin nerr++; $display("FAIL dbz_start got %0d pulses want 0", start_cnt - s0); end
    endtask

    task automatic test_hold();
        res_t got, exp;
        int   lat, bad;
        out_ready = 1'b0;
        exp = ref_div(200, 11);
        do_req(200, 11, got, lat);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== got.q ||
                out_remainder !== got.r || out_dbz !== got.dbz ||
                div_dividend !== 8'd200 || div_divisor !== 4'd11) bad++;
        end
        nvec++; if (got.q !== exp.q || got.r !== exp.r)
            begin nerr++; $display("FAIL hold_result got %0d/%0d want %0d/%0d", got.q, got.r, exp.q, exp.r); end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin nerr++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int a_t[3] = '{100, 200, 255};
        int b_t[3] = '{7, 13, 15};
        int s0, n, d0;
        res_t exp;
        out_ready = 1'b1;
        resq.delete();
        accq.delete();
        s0 = start_cnt;
        d0 = dbl_start;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            in_dividend = 8'(a_t[i]);
            in_divisor  = 4'(b_t[i]);
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (resq.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvec++; if (resq.size() != 3) begin nerr++; $display("FAIL b2b_count got %0d want 3", resq.size()); end
        for (int i = 0; i < 3 && i < resq.size(); i++) begin
            exp = ref_div(a_t[i], b_t[i]);
            nvec++; if (resq[i].q !== exp.q || resq[i].r !== exp.r || resq[i].dbz !== exp.dbz)
                begin nerr++; $display("FAIL b2b_res[%0d] got %0d/%0d want %0d/%0d", i, resq[i].q, resq[i].r, exp.q, exp.r); end
        end
        nvec++; if (accq.size() != 3) begin nerr++; $display("FAIL b2b_accepts got %0d want 3", accq.size()); end
        for (int i = 1; i < 3 && i < accq.size(); i++) begin
            nvec++; if (accq[i] - accq[i-1] != WC + 3)
                begin nerr++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i, accq[i] - accq[i-1], WC + 3); end
        end
        nvec++; if (start_cnt - s0 != 3) begin nerr++; $display("FAIL b2b_starts got %0d want 3", start_cnt - s0); end
        nvec++; if (dbl_start != d0) begin nerr++; $display("FAIL b2b_start_width got %0d wide pulses want 0", dbl_start - d0); end
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        int   lat, seen, n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin nerr++; $display("FAIL rstmid_state got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        rst_n = 1'b1;
        seen = 0;
        repeat (WC + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        nvec++; if (seen != 0) begin nerr++; $display("FAIL rstmid_no_result got %0d valid cycles want 0", seen); end
        exp = ref_div(100, 7);
        do_req(100, 7, got, lat);
        @(negedge clk);
        nvec++; if (got.q !== exp.q || got.r !== exp.r || got.dbz !== 1'b0 || lat != NORM_LAT)
            begin nerr++; $display("FAIL rstmid_fresh got %0d/%0d lat %0d want %0d/%0d lat %0d", got.q, got.r, lat, exp.q, exp.r, NORM_LAT); end
    endtask

    task automatic test_random();
        res_t got, exp;
        int   a, b, hold, lat, bad;
        for (int i = 0; i < 40; i++) begin
            a    = int'($urandom_range(0, 255));
            b    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            hold = int'($urandom_range(0, 3));
            exp  = ref_div(a, b);
            out_ready = (hold == 0);
            do_req(a, b, got, lat);
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!out_valid || out_quotient !== got.q || out_remainder !== got.r || out_dbz !== got.dbz) bad++;
            end
            out_ready = 1'b1;
            @(negedge clk);
            nvec++; if (got.q !== exp.q || got.r !== exp.r || got.dbz !== exp.dbz)
                begin nerr++; $display("FAIL rnd_res[%0d] %0d/%0d got %0d/%0d/%b want %0d/%0d/%b", i, a, b, got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz); end
            nvec++; if (lat != ref_lat(b))
                begin nerr++; $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, ref_lat(b)); end
            nvec++; if (bad != 0)
                begin nerr++; $display("FAIL rnd_hold[%0d] got %0d unstable cycles want 0", i, bad); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
